// File: rtl/regfile_pkg.sv
// Shared register-file definitions: FSM state encoding and default geometry.
// Used by the register file itself and by decode/writeback for matching widths.
package regfile_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ABITS    = 5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero-register, out-of-range, write bypass, array.
// Zero latency; outputs forced to 0 while the file is not ready.
module regfile_rdport #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32,
    parameter int ABITS    = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             ready,
    input  logic [ABITS-1:0] rd_addr,
    input  logic [WIDTH-1:0] arr_dat,
    input  logic             arr_busy,
    input  logic             wr_en,
    input  logic [ABITS-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_dat,
    output logic             rd_busy
);

    localparam logic [ABITS:0] NREGS = (ABITS+1)'(NUM_REGS);

    logic force_zero;

    always_comb begin
        force_zero = !ready
                   || ({1'b0, rd_addr} >= NREGS)
                   || ((ZERO_REG != 0) && (rd_addr == '0));
        rd_dat  = '0;
        rd_busy = 1'b0;
        if (!force_zero) begin
            // A same-cycle writeback produces the value, so it is never busy.
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_dat = wr_data;
            end else begin
                rd_dat  = arr_dat;
                rd_busy = arr_busy;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with busy scoreboard, write bypass and a one-register-per-cycle clear engine.
// Reads are combinational; writes land next edge; all traffic is ignored until ready.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ABITS    = DEF_ABITS,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_req,
    output logic                    ready,
    input  logic                    wr_en,
    input  logic [ABITS-1:0]        wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    claim_en,
    input  logic [ABITS-1:0]        claim_addr,
    output logic                    claim_ok,
    input  logic [NUM_RD*ABITS-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_busy
);

    localparam logic [ABITS:0]   NREGS    = (ABITS+1)'(NUM_REGS);
    localparam logic [ABITS-1:0] LAST_IDX = ABITS'(NUM_REGS - 1);

    state_e               state_q, state_d;
    logic [ABITS-1:0]     clr_idx_q, clr_idx_d;
    logic                 ready_q, ready_d;
    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic [WIDTH-1:0]     mem_q [NUM_REGS];

    logic                 mem_we;
    logic [ABITS-1:0]     mem_waddr;
    logic [WIDTH-1:0]     mem_wdata;

    logic                 wr_ok;
    logic                 claim_in_rng;
    logic                 claim_zero;
    logic                 claim_busy;
    logic                 claim_take;

    assign ready = ready_q;

    always_comb begin
        wr_ok = ready_q && wr_en
             && ({1'b0, wr_addr} < NREGS)
             && !((ZERO_REG != 0) && (wr_addr == '0));
        claim_in_rng = ({1'b0, claim_addr} < NREGS);
        claim_zero   = (ZERO_REG != 0) && (claim_addr == '0);
        // A writeback this cycle frees the register, so it may be re-claimed now.
        claim_busy = 1'b0;
        if (claim_in_rng && !claim_zero) begin
            claim_busy = busy_q[claim_addr] && !(wr_ok && (wr_addr == claim_addr));
        end
        claim_ok   = ready_q && !claim_busy;
        claim_take = claim_en && claim_ok && claim_in_rng && !claim_zero;
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        case (state_q)
            ST_CLEAR: begin
                mem_we            = 1'b1;
                mem_waddr         = clr_idx_q;
                mem_wdata         = '0;
                busy_d[clr_idx_q] = 1'b0;
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = ST_RUN;
                    ready_d   = 1'b1;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + ABITS'(1);
                end
            end
            ST_RUN: begin
                if (wr_ok) begin
                    mem_we          = 1'b1;
                    busy_d[wr_addr] = 1'b0;
                end
                // Claim after write: a new producer owns the register.
                if (claim_take) begin
                    busy_d[claim_addr] = 1'b1;
                end
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    ready_d   = 1'b0;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                ready_d   = 1'b0;
                clr_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    // The array has no reset; the clear sequence zeros it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ABITS-1:0] addr;
        logic [WIDTH-1:0] arr_dat;
        logic             arr_busy;

        assign addr = rd_addr[i*ABITS +: ABITS];

        always_comb begin
            arr_dat  = '0;
            arr_busy = 1'b0;
            if ({1'b0, addr} < NREGS) begin
                arr_dat  = mem_q[addr];
                arr_busy = busy_q[addr];
            end
        end

        regfile_rdport #(
            .WIDTH    (WIDTH),
            .NUM_REGS (NUM_REGS),
            .ABITS    (ABITS),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .ready    (ready_q),
            .rd_addr  (addr),
            .arr_dat  (arr_dat),
            .arr_busy (arr_busy),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_dat   (rd_data[i*WIDTH +: WIDTH]),
            .rd_busy  (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset/clear timing, bypass, zero register, scoreboard.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_req;
    logic        ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic        claim_ok;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_req  (clear_req),
        .ready      (ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .claim_ok   (claim_ok),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy)
    );

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        claim_en;
        logic [4:0]  claim_addr;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        eb0;
        logic        eb1;
        logic        eok;
    } vec_t;

    vec_t vt [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle();
        clear_req  = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = 5'd0;
        wr_data    = 32'd0;
        claim_en   = 1'b0;
        claim_addr = 5'd0;
        rd_addr    = 10'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready rises, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic [31:0] exp_v;
        logic        busy_any;

        vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b1};
        vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b1};
        vt[2]  = '{1'b1, 5'd0,  32'h1234,     1'b1, 5'd0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  5'd7,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7, 5'd7,  5'd7,  32'h0,        32'h0,        1'b1, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 5'd7,  32'h55,       1'b0, 5'd7, 5'd7,  5'd7,  32'h55,       32'h55,       1'b0, 1'b0, 1'b1};
        vt[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7, 5'd7,  5'd5,  32'h55,       32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 5'd7,  32'h66,       1'b1, 5'd7, 5'd7,  5'd7,  32'h66,       32'h66,       1'b0, 1'b0, 1'b1};
        vt[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7, 5'd7,  5'd5,  32'h66,       32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
        vt[11] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd31, 5'd30, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 1'b1};
        vt[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd31, 5'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1};

        // Reset state
        rst_n = 1'b0;
        idle();
        rd_addr = {5'd3, 5'd5};
        #2;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_claim_ok", {31'd0, claim_ok}, 32'd0);
        check("rst_rd0", rd_data[31:0], 32'd0);
        check("rst_rd1", rd_data[63:32], 32'd0);
        check("rst_busy", {30'd0, rd_busy}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        check("init_clear_edges", n, 32);
        idle();
        #1;

        // Table-driven vectors in RUN
        for (int i = 0; i < 13; i++) begin
            wr_en      = vt[i].wr_en;
            wr_addr    = vt[i].wr_addr;
            wr_data    = vt[i].wr_data;
            claim_en   = vt[i].claim_en;
            claim_addr = vt[i].claim_addr;
            rd_addr    = {vt[i].a1, vt[i].a0};
            #2;
            check($sformatf("v%0d_rd0", i), rd_data[31:0], vt[i].e0);
            check($sformatf("v%0d_rd1", i), rd_data[63:32], vt[i].e1);
            check($sformatf("v%0d_busy0", i), {31'd0, rd_busy[0]}, {31'd0, vt[i].eb0});
            check($sformatf("v%0d_busy1", i), {31'd0, rd_busy[1]}, {31'd0, vt[i].eb1});
            check($sformatf("v%0d_claim_ok", i), {31'd0, claim_ok}, {31'd0, vt[i].eok});
            tick();
        end
        idle();

        // Populate r1..r31, then claim r3
        for (int i = 1; i < 32; i++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            wr_data = 32'h100 + 32'(i);
            tick();
        end
        idle();
        claim_en   = 1'b1;
        claim_addr = 5'd3;
        tick();
        idle();
        rd_addr = {5'd31, 5'd3};
        #2;
        check("pop_r3_busy", {31'd0, rd_busy[0]}, 32'd1);
        check("pop_r3_data", rd_data[31:0], 32'h103);
        check("pop_r31_data", rd_data[63:32], 32'h11F);

        // clear_req with a same-cycle write, and a write/claim during CLEAR
        clear_req = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 5'd9;
        wr_data   = 32'h999;
        tick();
        idle();
        #1;
        check("clr_ready_low", {31'd0, ready}, 32'd0);
        check("clr_claim_ok", {31'd0, claim_ok}, 32'd0);
        n = 0;
        while (!ready && n < 100) begin
            if (n == 20) begin
                wr_en      = 1'b1;
                wr_addr    = 5'd2;
                wr_data    = 32'h77;
                claim_en   = 1'b1;
                claim_addr = 5'd4;
            end else begin
                idle();
            end
            tick();
            n++;
        end
        idle();
        check("clr_edges", n, 32);
        busy_any = 1'b0;
        for (int r = 0; r < 32; r++) begin
            rd_addr = {5'(r), 5'(r)};
            #1;
            check($sformatf("clr_r%0d", r), rd_data[31:0], 32'd0);
            busy_any = busy_any | rd_busy[0] | rd_busy[1];
        end
        check("clr_busy_any", {31'd0, busy_any}, 32'd0);

        // Reset mid-CLEAR at clr_idx 10
        wr_en   = 1'b1;
        wr_addr = 5'd12;
        wr_data = 32'hC0FFEE;
        tick();
        idle();
        clear_req = 1'b1;
        tick();
        idle();
        for (int k = 0; k < 10; k++) tick();
        rst_n = 1'b0;
        #2;
        check("midclr_rst_ready", {31'd0, ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        check("midclr_edges", n, 32);
        rd_addr = {5'd12, 5'd12};
        #1;
        check("midclr_r12", rd_data[31:0], 32'd0);

        // Reset mid-RUN clears busy and ready immediately
        claim_en   = 1'b1;
        claim_addr = 5'd8;
        tick();
        idle();
        rd_addr = {5'd8, 5'd8};
        #1;
        check("run_r8_busy", {31'd0, rd_busy[0]}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_ready", {31'd0, ready}, 32'd0);
        check("midrun_rst_claim_ok", {31'd0, claim_ok}, 32'd0);
        check("midrun_rst_busy", {30'd0, rd_busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        check("midrun_edges", n, 32);
        #1;
        exp_v = 32'd0;
        check("midrun_r8_busy_after", {31'd0, rd_busy[0]}, exp_v);
        claim_addr = 5'd8;
        #1;
        check("midrun_r8_claim_ok", {31'd0, claim_ok}, 32'd1);
        idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
